// File: rtl/packetizer_1_sub_if.sv
// Upstream word handshake plus downstream flit channel of the single-flit packetizer.
interface packetizer_1_sub_if #(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 12,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
);
  logic [WIDTH_DATA-1:0]       data_in;
  logic                        valid_in;
  logic                        ready_out;
  logic [ADDRESS_WIDTH-1:0]    dest_in;
  logic [VC_ADDRESS_WIDTH-1:0] vc_in;
  logic [WIDTH_PKT-1:0]        data_out;
  logic                        ready_in;

  modport master (
    output data_in, valid_in, dest_in, vc_in, ready_in,
    input  ready_out, data_out
  );

  modport slave (
    input  data_in, valid_in, dest_in, vc_in, ready_in,
    output ready_out, data_out
  );
endinterface

// File: rtl/packetizer_1_sub.sv
// Formats a data word into a one-flit NoC packet (valid/head/tail/vc/dest/data) and queues it in a
// 2-entry registered skid FIFO; 1-cycle latency when empty, ready_out depends only on registered count.
module packetizer_1_sub #(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 12,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packetizer_1_sub_if.slave    bus
);

  localparam int WIDTH_DATA_IDL = WIDTH_PKT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int EXTRA_BITS     = WIDTH_DATA_IDL - WIDTH_DATA;

  generate
    if (EXTRA_BITS < 0) begin : g_width_check
      $error("packetizer_1_sub: WIDTH_DATA does not fit in the packet data field");
    end
  endgenerate

  logic [WIDTH_PKT-1:0] pkt0_q, pkt0_d;
  logic [WIDTH_PKT-1:0] pkt1_q, pkt1_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 rdy_en_q, rdy_en_d;

  logic [WIDTH_PKT-1:0] fmt_pkt;
  logic                 ready_w;
  logic                 push;
  logic                 pop;

  // rdy_en_q keeps ready_out low through reset and until the first edge after release.
  assign ready_w       = rdy_en_q && (count_q != 2'd2);
  assign bus.ready_out = ready_w;
  assign bus.data_out  = (count_q != 2'd0) ? (rd_ptr_q ? pkt1_q : pkt0_q) : '0;

  always_comb begin
    fmt_pkt                                                   = '0;
    fmt_pkt[WIDTH_PKT-1]                                      = 1'b1;
    fmt_pkt[WIDTH_PKT-2]                                      = 1'b1;
    fmt_pkt[WIDTH_PKT-3]                                      = 1'b1;
    fmt_pkt[WIDTH_PKT-4 -: VC_ADDRESS_WIDTH]                  = bus.vc_in;
    fmt_pkt[WIDTH_PKT-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH]    = bus.dest_in;
    fmt_pkt[WIDTH_DATA_IDL-1 -: WIDTH_DATA]                   = bus.data_in;
  end

  always_comb begin
    pkt0_d   = pkt0_q;
    pkt1_d   = pkt1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rdy_en_d = 1'b1;

    push = bus.valid_in && ready_w;
    pop  = (count_q != 2'd0) && bus.ready_in;

    if (push) begin
      if (wr_ptr_q) begin
        pkt1_d = fmt_pkt;
      end else begin
        pkt0_d = fmt_pkt;
      end
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt0_q   <= '0;
      pkt1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      pkt0_q   <= pkt0_d;
      pkt1_q   <= pkt1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_packetizer_1_sub.sv
// Bench for packetizer_1_sub: queue-based reference model checked every cycle, plus directed literal checks.
module tb_packetizer_1_sub;

  typedef struct packed {
    logic [11:0] d;
    logic [3:0]  a;
    logic        v;
  } word_t;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nfail;

  packetizer_1_sub_if bus ();

  packetizer_1_sub dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  word_t mq[$];
  bit    started;

  function automatic logic [35:0] mk(input word_t w);
    logic [63:0] p;
    p = (64'd7 << 33) + (64'(w.v) << 32) + (64'(w.a) << 28) + (64'(w.d) << 16);
    return p[35:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a queue of at most two words; ready once the first post-reset edge has passed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      started = 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      word_t w;
      do_push = bus.valid_in && started && (mq.size() < 2);
      do_pop  = (mq.size() != 0) && bus.ready_in;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        w.d = bus.data_in;
        w.a = bus.dest_in;
        w.v = bus.vc_in;
        mq.push_back(w);
      end
      started = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [35:0] exp_out;
    exp_out = (mq.size() != 0) ? mk(mq[0]) : 36'h0;
    chk("cyc_data_out", 64'(bus.data_out), 64'(exp_out));
    chk("cyc_ready_out", 64'(bus.ready_out), 64'(started && (mq.size() < 2)));
    if ((mq.size() != 0) && bus.ready_in) begin
      chk("rt_fields", {45'h0, bus.data_out[27:16], bus.data_out[31:28], bus.data_out[32]},
          {45'h0, mq[0].d, mq[0].a, mq[0].v});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vi, input logic [11:0] d, input logic [3:0] a, input logic v);
    bus.valid_in = vi;
    bus.data_in  = d;
    bus.dest_in  = a;
    bus.vc_in    = v;
  endtask

  initial begin
    word_t w;
    int acc;
    int cyc;
    nchk  = 0;
    nfail = 0;
    rst_n = 1'b0;
    bus.ready_in = 1'b0;
    drive(1'b0, 12'h0, 4'h0, 1'b0);
    #1;
    chk("reset_data_out", 64'(bus.data_out), 64'h0);
    chk("reset_ready_out", 64'(bus.ready_out), 64'h0);

    step();
    step();
    #3 rst_n = 1'b1;
    #1 chk("ready_before_edge", 64'(bus.ready_out), 64'h0);
    step();
    chk("ready_after_edge", 64'(bus.ready_out), 64'h1);

    // Single word, VC 1
    bus.ready_in = 1'b1;
    drive(1'b1, 12'hABC, 4'h5, 1'b1);
    step();
    drive(1'b0, 12'h123, 4'hA, 1'b0);
    chk("single_word", 64'(bus.data_out), 64'hF5ABC0000);
    step();
    chk("single_word_gone", 64'(bus.data_out), 64'h0);

    // VC 0 and field isolation
    drive(1'b1, 12'hABC, 4'h5, 1'b0);
    step();
    drive(1'b0, 12'hFFF, 4'hF, 1'b1);
    chk("vc0_word", 64'(bus.data_out), 64'hE5ABC0000);
    step();
    drive(1'b1, 12'hFFF, 4'h0, 1'b0);
    step();
    drive(1'b0, 12'h0, 4'h0, 1'b0);
    chk("fff_dest0", 64'(bus.data_out), 64'hE0FFF0000);
    chk("low_bits_zero", 64'(bus.data_out[15:0]), 64'h0);
    step();

    // Backpressure fill
    bus.ready_in = 1'b0;
    drive(1'b1, 12'h001, 4'h1, 1'b0);
    step();
    chk("bp_ready_after_1", 64'(bus.ready_out), 64'h1);
    drive(1'b1, 12'h002, 4'h2, 1'b0);
    step();
    chk("bp_full_ready", 64'(bus.ready_out), 64'h0);
    chk("bp_hold_w1", 64'(bus.data_out), 64'hE10010000);
    drive(1'b1, 12'h003, 4'h3, 1'b0);
    step();
    step();
    chk("bp_still_w1", 64'(bus.data_out), 64'hE10010000);
    bus.ready_in = 1'b1;
    step();
    chk("bp_out_w2", 64'(bus.data_out), 64'hE20020000);
    step();
    drive(1'b0, 12'h0, 4'h0, 1'b0);
    chk("bp_out_w3", 64'(bus.data_out), 64'hE30030000);
    step();
    chk("bp_drained", 64'(bus.data_out), 64'h0);

    // Streaming: simultaneous push and pop every cycle
    for (int i = 0; i < 20; i++) begin
      w.d = 12'($urandom);
      w.a = 4'($urandom);
      w.v = 1'($urandom);
      drive(1'b1, w.d, w.a, w.v);
      step();
      chk("stream_ready", 64'(bus.ready_out), 64'h1);
      chk("stream_word", 64'(bus.data_out), 64'(mk(w)));
    end
    drive(1'b0, 12'h0, 4'h0, 1'b0);
    step();

    // Random stress
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      drive($urandom_range(0, 3) != 0, 12'($urandom), 4'($urandom), 1'($urandom));
      bus.ready_in = ($urandom_range(0, 2) != 0);
      if (bus.valid_in && bus.ready_out) acc++;
      step();
      cyc++;
    end
    chk("stress_completed", 64'(acc >= 1000), 64'h1);
    drive(1'b0, 12'h0, 4'h0, 1'b0);
    bus.ready_in = 1'b1;
    step();
    step();
    step();
    chk("stress_drained", 64'(bus.data_out), 64'h0);

    // Reset with a full FIFO
    bus.ready_in = 1'b0;
    drive(1'b1, 12'h5A5, 4'h7, 1'b1);
    step();
    drive(1'b1, 12'h3C3, 4'h9, 1'b0);
    step();
    chk("pre_reset_full", 64'(bus.ready_out), 64'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_data_out", 64'(bus.data_out), 64'h0);
    chk("mid_reset_ready_out", 64'(bus.ready_out), 64'h0);
    drive(1'b0, 12'h0, 4'h0, 1'b0);
    bus.ready_in = 1'b1;
    step();
    #2 rst_n = 1'b1;
    #1 chk("post_reset_ready_low", 64'(bus.ready_out), 64'h0);
    step();
    chk("post_reset_ready_high", 64'(bus.ready_out), 64'h1);
    for (int i = 0; i < 4; i++) begin
      chk("no_stale_flit", 64'(bus.data_out[35]), 64'h0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/packetizer_1_sub.md
Name: packetizer_1_sub

Overview:
- Transmit-side counterpart of the single-flit depacketizer.
- Takes a WIDTH_DATA-bit data word with valid/ready handshake, plus a per-word destination router address and VC.
- Builds a one-flit NoC packet: valid, head and tail control bits, VC, destination address, then data.
- Buffers up to two packets in a registered skid buffer, so ready_out never depends combinationally on ready_in.

Parameters:
- WIDTH_PKT, 36, total flit width in bits.
- WIDTH_DATA, 12, user data width.
- VC_ADDRESS_WIDTH, 1, width of the VC field.
- ADDRESS_WIDTH, 4, width of the destination router address field.
- Derived: WIDTH_DATA_IDL = WIDTH_PKT-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH (28 at defaults).
- Derived: EXTRA_BITS = WIDTH_DATA_IDL-WIDTH_DATA (16 at defaults).
- Elaboration must fail if EXTRA_BITS < 0.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH_DATA  user data word.
- valid_in  in  1  data_in/dest_in/vc_in valid.
- ready_out  out  1  block can accept a word this cycle.
- dest_in  in  ADDRESS_WIDTH  destination router address, sampled with data_in.
- vc_in  in  VC_ADDRESS_WIDTH  virtual channel, sampled with data_in.
- data_out  out  WIDTH_PKT  packet toward NoC; bit WIDTH_PKT-1 is the flit-valid bit.
- ready_in  in  1  NoC/downstream accepts the flit on data_out this cycle.

Behaviour:
- Packet format, MSB to LSB:
  - [WIDTH_PKT-1] valid = 1
  - [WIDTH_PKT-2] head = 1
  - [WIDTH_PKT-3] tail = 1
  - next VC_ADDRESS_WIDTH bits = vc
  - next ADDRESS_WIDTH bits = dest
  - next WIDTH_DATA bits = data, MSB-aligned in the data field
  - low EXTRA_BITS = 0
- Round trip: data placement exactly matches depacketizer extraction, data_out[WIDTH_DATA_IDL-1 -: WIDTH_DATA].
- Storage: 2-entry FIFO (two packet registers, 1-bit read pointer, 1-bit write pointer, 2-bit count 0..2). Packets are formatted before storage.
- Accept: push when valid_in && ready_out.
- ready_out = (count != 2), decoded from registered count only.
- Issue: pop when count != 0 && ready_in.
- data_out = head entry when count != 0; all zeros when count == 0, so the valid bit is 0.
- No combinational path from ready_in or valid_in to ready_out or data_out.
- Latency: word accepted at edge N appears on data_out after edge N (cycle N+1) if the FIFO was empty.
- Steady state: full throughput, one word per cycle, when ready_in stays high.
- Count updates:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance
  - count==2: no push possible; pop alone goes to 1
  - count==0: no pop possible; data_out stays 0 even if ready_in=1
- Ordering: strict FIFO; no reordering, duplication or loss across any ready_in pattern.
- Backpressure: while ready_in=0, data_out holds its value bit-exact until popped.
- Reset, asynchronous, active-low:
  - count=0, pointers=0, packet registers=0.
  - Outputs during reset: data_out=0, ready_out=0.
  - ready_out rises on the first clock edge after rst_n deasserts.
- Reset mid-operation: buffered packets are discarded; data_out goes to 0 immediately.
- valid_in=0 cycles: nothing is stored and no flit is produced, regardless of data_in, dest_in and vc_in.

Test Plan (defaults):
- Single word:
  - Stimulus: data_in=12'hABC, dest_in=4'h5, vc_in=1, ready_in=1.
  - Response: one cycle later data_out=36'hF5ABC0000 for exactly one cycle, then 36'h0.
- VC 0 / field isolation:
  - Stimulus: data_in=12'hABC, dest_in=5, vc_in=0.
  - Response: data_out=36'hE5ABC0000.
  - Also: data_in=12'hFFF, dest_in=0 gives 36'hE0FFF0000; bits [15:0] are always zero.
- Backpressure fill:
  - Stimulus: ready_in=0; present words 1, 2, 3 continuously.
  - Response: words 1 and 2 accepted; ready_out=0 from the cycle after the second accept; data_out holds word 1 stable.
  - Then ready_in=1: words 1, 2, 3 emerge in order, one per cycle.
- Simultaneous push/pop at count=1:
  - Stimulus: valid_in=1 and ready_in=1 every cycle for 20 words.
  - Response: count stays 1, ready_out stays 1, 20 packets out in order with no bubbles.
- Random stress with scoreboard:
  - Stimulus: random valid_in and ready_in over 1000 words; data_out fed through depacketizer_1_sub.
  - Response: recovered data, dest and vc sequences equal the input sequence; no gaps or duplicates.
- Reset mid-operation:
  - Stimulus: count=2, then assert rst_n=0 asynchronously between edges.
  - Response: data_out=0 and ready_out=0 immediately; after release, ready_out=1 at the next edge; no stale packet ever emitted.
